// File: rtl/rom_load_pkg.sv
// rom_load_pkg
//   Shared types and constants for the ROM download controller.
//   - state_t      : controller FSM states
//   - *_INDEX_DEF  : default ioctl_index values for ROM, variant and DIP downloads
//   - DIP_DEFAULT  : DIP bank value after reset (all switches off)
package rom_load_pkg;

  typedef enum logic [2:0] {
    BOOT,
    LOAD,
    DRAIN,
    HOLD,
    RUN
  } state_t;

  localparam logic [7:0]  ROM_INDEX_DEF = 8'd0;
  localparam logic [7:0]  MOD_INDEX_DEF = 8'd1;
  localparam logic [7:0]  DIP_INDEX_DEF = 8'd254;
  localparam logic [63:0] DIP_DEFAULT   = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/rom_load_ctrl_if.sv
// rom_load_ctrl_if
//   Bundles the hps_io download stream, the ROM write port and the core
//   status/reset outputs of rom_load_ctrl. Names are seen from the controller:
//   i_* are driven by the host side, o_* by the controller.
//   modport slave  : the controller
//   modport master : the host / core side (hps_io, ROM sink, testbench)
interface rom_load_ctrl_if #(
  parameter int ROM_AW = 16
);
  logic              i_soft_reset;
  logic              i_ioctl_download;
  logic [7:0]        i_ioctl_index;
  logic              i_ioctl_wr;
  logic [24:0]       i_ioctl_addr;
  logic [7:0]        i_ioctl_dout;
  logic              o_ioctl_wait;
  logic              i_rom_busy;
  logic              o_rom_we;
  logic [ROM_AW-1:0] o_rom_addr;
  logic [7:0]        o_rom_data;
  logic [7:0]        o_mod;
  logic [63:0]       o_dipsw;
  logic              o_core_reset;
  logic              o_load_done;
  logic [ROM_AW:0]   o_byte_count;
  logic              o_load_err;

  modport slave (
    input  i_soft_reset, i_ioctl_download, i_ioctl_index, i_ioctl_wr,
    input  i_ioctl_addr, i_ioctl_dout, i_rom_busy,
    output o_ioctl_wait, o_rom_we, o_rom_addr, o_rom_data, o_mod, o_dipsw,
    output o_core_reset, o_load_done, o_byte_count, o_load_err
  );

  modport master (
    output i_soft_reset, i_ioctl_download, i_ioctl_index, i_ioctl_wr,
    output i_ioctl_addr, i_ioctl_dout, i_rom_busy,
    input  o_ioctl_wait, o_rom_we, o_rom_addr, o_rom_data, o_mod, o_dipsw,
    input  o_core_reset, o_load_done, o_byte_count, o_load_err
  );

endinterface

// File: rtl/load_skid.sv
// load_skid
//   One-entry address/data holding register for ROM bytes that could not be
//   written straight through. Push and pop in the same cycle is allowed: the
//   old entry leaves and the new one takes its place.
//   Ports: clk, rst (async, active high), i_push/i_addr/i_data (load entry),
//          i_pop (entry consumed), o_full/o_addr/o_data (held entry).
module load_skid #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_data,
  output logic          o_full,
  output logic [AW-1:0] o_addr,
  output logic [7:0]    o_data
);
  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_full = r_valid;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl
//   Sequences the hps_io download stream for the arcade core: ROM bytes go to
//   the core ROM write port (paced with ioctl_wait when the sink is busy), the
//   variant byte and the 8-byte DIP bank are latched, and the core reset is
//   held through power-up, ROM loads, variant changes and soft resets, then
//   released HOLD_CYCLES cycles after entering HOLD.
//   Ports: clk, rst (async, active high), bus (rom_load_ctrl_if.slave) carrying
//          the ioctl stream, ROM write port, mod/dipsw and status outputs.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int         ROM_AW      = 16,
  parameter int         HOLD_CYCLES = 1024,
  parameter logic [7:0] ROM_INDEX   = ROM_INDEX_DEF,
  parameter logic [7:0] MOD_INDEX   = MOD_INDEX_DEF,
  parameter logic [7:0] DIP_INDEX   = DIP_INDEX_DEF
) (
  input logic            clk,
  input logic            rst,
  rom_load_ctrl_if.slave bus
);
  localparam int              CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [ROM_AW:0] COUNT_MAX = {1'b1, {ROM_AW{1'b0}}};

  state_t            r_state;
  logic              r_core_reset;
  logic              r_load_done;
  logic              r_dl_prev;
  logic [CW-1:0]     r_hold_cnt;
  logic              r_rom_we;
  logic [ROM_AW-1:0] r_rom_addr;
  logic [7:0]        r_rom_data;
  logic [7:0]        r_mod;
  logic [ROM_AW:0]   r_byte_count;
  logic              r_load_err;

  logic              w_skid_full;
  logic [ROM_AW-1:0] w_skid_addr;
  logic [7:0]        w_skid_data;

  logic w_load_start, w_rom_wr, w_in_range, w_accept, w_oor;
  logic w_pop, w_direct, w_push, w_drop, w_issue, w_mod_wr, w_dip_wr, w_hold_req;

  assign w_load_start = bus.i_ioctl_download && !r_dl_prev && (bus.i_ioctl_index == ROM_INDEX);
  assign w_rom_wr     = bus.i_ioctl_wr && (bus.i_ioctl_index == ROM_INDEX);
  assign w_in_range   = (bus.i_ioctl_addr[24:ROM_AW] == '0);
  assign w_accept     = w_rom_wr && w_in_range;
  assign w_oor        = w_rom_wr && !w_in_range;
  // The held byte always goes out before any newer one; a new byte bypasses
  // the buffer only when it is empty and the sink is ready.
  assign w_pop        = w_skid_full && !bus.i_rom_busy;
  assign w_direct     = w_accept && !w_skid_full && !bus.i_rom_busy;
  assign w_push       = w_accept && !w_direct && (!w_skid_full || w_pop);
  assign w_drop       = w_accept && w_skid_full && !w_pop;
  assign w_issue      = w_pop || w_direct;
  assign w_mod_wr     = bus.i_ioctl_wr && (bus.i_ioctl_index == MOD_INDEX);
  assign w_dip_wr     = bus.i_ioctl_wr && (bus.i_ioctl_index == DIP_INDEX) &&
                        (bus.i_ioctl_addr[24:3] == '0);
  assign w_hold_req   = bus.i_soft_reset || w_mod_wr;

  load_skid #(.AW(ROM_AW)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_addr (bus.i_ioctl_addr[ROM_AW-1:0]),
    .i_data (bus.i_ioctl_dout),
    .o_full (w_skid_full),
    .o_addr (w_skid_addr),
    .o_data (w_skid_data)
  );

  // Controller FSM with registered core reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= BOOT;
      r_core_reset <= 1'b1;
      r_load_done  <= 1'b0;
      r_dl_prev    <= 1'b0;
      r_hold_cnt   <= '0;
    end else begin
      r_dl_prev <= bus.i_ioctl_download;
      if (w_load_start) begin
        r_state      <= LOAD;
        r_core_reset <= 1'b1;
      end else begin
        case (r_state)
          BOOT: if (r_load_done) begin
            r_state    <= HOLD;
            r_hold_cnt <= HOLD_LOAD;
          end
          LOAD: if (!bus.i_ioctl_download) r_state <= DRAIN;
          DRAIN: if (!w_skid_full) begin
            r_state     <= HOLD;
            r_hold_cnt  <= HOLD_LOAD;
            r_load_done <= 1'b1;
          end
          HOLD: begin
            // A fresh request restarts the full hold period.
            if (w_hold_req) begin
              r_hold_cnt <= HOLD_LOAD;
            end else if (r_hold_cnt == '0) begin
              r_state      <= RUN;
              r_core_reset <= 1'b0;
            end else begin
              r_hold_cnt <= r_hold_cnt - CW'(1);
            end
          end
          RUN: if (w_hold_req) begin
            r_state      <= HOLD;
            r_hold_cnt   <= HOLD_LOAD;
            r_core_reset <= 1'b1;
          end
          default: r_state <= BOOT;
        endcase
      end
    end
  end

  // ROM write port, byte counter, error flag and variant byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_we     <= 1'b0;
      r_rom_addr   <= '0;
      r_rom_data   <= '0;
      r_byte_count <= '0;
      r_load_err   <= 1'b0;
      r_mod        <= '0;
    end else begin
      r_rom_we <= w_issue;
      if (w_pop) begin
        r_rom_addr <= w_skid_addr;
        r_rom_data <= w_skid_data;
      end else if (w_direct) begin
        r_rom_addr <= bus.i_ioctl_addr[ROM_AW-1:0];
        r_rom_data <= bus.i_ioctl_dout;
      end
      if (w_load_start) begin
        r_byte_count <= '0;
        r_load_err   <= 1'b0;
      end else begin
        if (w_issue && (r_byte_count != COUNT_MAX))
          r_byte_count <= r_byte_count + (ROM_AW+1)'(1);
        if (w_drop || w_oor)
          r_load_err <= 1'b1;
      end
      if (w_mod_wr)
        r_mod <= bus.i_ioctl_dout;
    end
  end

  // DIP bank: one register per byte, selected by ioctl_addr[2:0].
  for (genvar gi = 0; gi < 8; gi++) begin : g_dip
    logic [7:0] r_byte;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_byte <= DIP_DEFAULT[8*gi +: 8];
      else if (w_dip_wr && (bus.i_ioctl_addr[2:0] == 3'(gi)))
        r_byte <= bus.i_ioctl_dout;
    end
    assign bus.o_dipsw[8*gi +: 8] = r_byte;
  end

  assign bus.o_ioctl_wait = w_skid_full;
  assign bus.o_rom_we     = r_rom_we;
  assign bus.o_rom_addr   = r_rom_addr;
  assign bus.o_rom_data   = r_rom_data;
  assign bus.o_mod        = r_mod;
  assign bus.o_core_reset = r_core_reset;
  assign bus.o_load_done  = r_load_done;
  assign bus.o_byte_count = r_byte_count;
  assign bus.o_load_err   = r_load_err;

endmodule
